// File: rtl/score_display_bcd_if.sv
// Signal bundle between the game logic / VGA timing generator and the score renderer.
// The master side drives game events and pixel coordinates; the slave side returns colour and status.
interface score_display_bcd_if;
  logic       frame_tick;
  logic       point_p1;
  logic       point_p2;
  logic       restart;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       red;
  logic       green;
  logic       blue;
  logic [7:0] score_p1;
  logic [7:0] score_p2;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output frame_tick, point_p1, point_p2, restart, h_count, v_count,
    input  red, green, blue, score_p1, score_p2, game_over, winner
  );

  modport slave (
    input  frame_tick, point_p1, point_p2, restart, h_count, v_count,
    output red, green, blue, score_p1, score_p2, game_over, winner
  );
endinterface

// File: rtl/score_display_bcd.sv
// Two-player BCD score keeper for vPong: counts points, blinks the scorer, detects the win
// and draws both scores as 7-segment digits into the green channel of the pixel stream.
module score_display_bcd #(
  parameter int SEG_LEN      = 40,
  parameter int SEG_THK      = 10,
  parameter int DIGIT_X      = 550,
  parameter int DIGIT_GAP    = 20,
  parameter int P1_Y         = 20,
  parameter int P2_Y         = 380,
  parameter int MAX_SCORE    = 10,
  parameter int FLASH_FRAMES = 60,
  parameter int BLINK_FRAMES = 8
) (
  input logic                clk,
  input logic                reset,
  score_display_bcd_if.slave bus
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    WIN   = 2'd2
  } state_t;

  localparam int         FC_W    = $clog2(FLASH_FRAMES + 1);
  localparam int         BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0] MAX_BCD = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

  // All pixel geometry is evaluated in 11 bits so X+L etc. cannot wrap near 1023.
  localparam logic [10:0] LEN_W  = 11'(SEG_LEN);
  localparam logic [10:0] THK_W  = 11'(SEG_THK);
  localparam logic [10:0] V_W    = 11'(SEG_LEN - SEG_THK);
  localparam logic [10:0] V2_W   = 11'(2 * (SEG_LEN - SEG_THK));
  localparam logic [10:0] UNIT_X = 11'(DIGIT_X);
  localparam logic [10:0] TENS_X = 11'(DIGIT_X - SEG_LEN - DIGIT_GAP);
  localparam logic [10:0] P1_YW  = 11'(P1_Y);
  localparam logic [10:0] P2_YW  = 11'(P2_Y);

  state_t          state_r;
  state_t          state_s;
  logic [7:0]      score1_r;
  logic [7:0]      score2_r;
  logic [7:0]      score1_s;
  logic [7:0]      score2_s;
  logic [1:0]      reach_s;
  logic            point_accept_s;
  logic [FC_W-1:0] flash_cnt_r;
  logic [BC_W-1:0] blink_cnt_r;
  logic            blink_hide_r;
  logic [1:0]      flash_mask_r;
  logic [1:0]      winner_r;
  logic [1:0]      blink_mask_s;
  logic [1:0]      visible_s;
  logic            game_over_s;
  logic [10:0]     x_s;
  logic [10:0]     y_s;
  logic [6:0]      tens1_seg_s;
  logic [6:0]      unit1_seg_s;
  logic [6:0]      tens2_seg_s;
  logic [6:0]      unit2_seg_s;
  logic            pix_s;
  logic            green_r;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Segment bits ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_map(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1110011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic digit_hit(input logic [10:0] x, input logic [10:0] y,
                                     input logic [10:0] ox, input logic [10:0] oy,
                                     input logic [6:0] segs);
    logic col_full;
    logic col_left;
    logic col_right;
    logic row_a;
    logic row_g;
    logic row_d;
    logic row_up;
    logic row_lo;
    col_full  = (x >= ox) && (x < ox + LEN_W);
    col_left  = (x >= ox) && (x < ox + THK_W);
    col_right = (x >= ox + V_W) && (x < ox + LEN_W);
    row_a     = (y >= oy) && (y < oy + THK_W);
    row_g     = (y >= oy + V_W) && (y < oy + V_W + THK_W);
    row_d     = (y >= oy + V2_W) && (y < oy + V2_W + THK_W);
    row_up    = (y >= oy) && (y < oy + V_W + THK_W);
    row_lo    = (y >= oy + V_W) && (y < oy + V2_W + THK_W);
    return (segs[6] & col_full  & row_a)  |
           (segs[5] & col_right & row_up) |
           (segs[4] & col_right & row_lo) |
           (segs[3] & col_full  & row_d)  |
           (segs[2] & col_left  & row_lo) |
           (segs[1] & col_left  & row_up) |
           (segs[0] & col_full  & row_g);
  endfunction

  // Point acceptance and next BCD scores; restart and the WIN state swallow points
  always_comb begin
    point_accept_s = 1'b0;
    score1_s       = score1_r;
    score2_s       = score2_r;
    if (!bus.restart && (state_r != WIN) && (bus.point_p1 || bus.point_p2)) begin
      point_accept_s = 1'b1;
      if (bus.point_p1 && (score1_r != MAX_BCD)) begin
        score1_s = bcd_inc(score1_r);
      end else begin
        score1_s = score1_r;
      end
      if (bus.point_p2 && (score2_r != MAX_BCD)) begin
        score2_s = bcd_inc(score2_r);
      end else begin
        score2_s = score2_r;
      end
    end else begin
      point_accept_s = 1'b0;
    end
    reach_s = {score2_s == MAX_BCD, score1_s == MAX_BCD};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= PLAY;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    if (bus.restart) begin
      state_s = PLAY;
    end else begin
      case (state_r)
        PLAY: begin
          if (point_accept_s) begin
            state_s = (reach_s != 2'b00) ? WIN : FLASH;
          end else begin
            state_s = PLAY;
          end
        end
        FLASH: begin
          if (point_accept_s) begin
            state_s = (reach_s != 2'b00) ? WIN : FLASH;
          end else if (flash_cnt_r == FC_W'(FLASH_FRAMES)) begin
            state_s = PLAY;
          end else begin
            state_s = FLASH;
          end
        end
        WIN:     state_s = WIN;
        default: state_s = PLAY;
      endcase
    end
  end

  // FSM outputs: which players blink and the game-over flag
  always_comb begin
    blink_mask_s = 2'b00;
    game_over_s  = 1'b0;
    case (state_r)
      PLAY: begin
        blink_mask_s = 2'b00;
        game_over_s  = 1'b0;
      end
      FLASH: begin
        blink_mask_s = flash_mask_r;
        game_over_s  = 1'b0;
      end
      WIN: begin
        blink_mask_s = winner_r;
        game_over_s  = 1'b1;
      end
      default: begin
        blink_mask_s = 2'b00;
        game_over_s  = 1'b0;
      end
    endcase
    visible_s = ~(blink_mask_s & {2{blink_hide_r}});
  end

  // Scores, flash/blink counters, flash mask and winner
  always_ff @(posedge clk) begin
    if (reset || bus.restart) begin
      score1_r     <= 8'h00;
      score2_r     <= 8'h00;
      flash_cnt_r  <= '0;
      blink_cnt_r  <= '0;
      blink_hide_r <= 1'b0;
      flash_mask_r <= 2'b00;
      winner_r     <= 2'b00;
    end else if (point_accept_s) begin
      score1_r     <= score1_s;
      score2_r     <= score2_s;
      flash_cnt_r  <= '0;
      blink_cnt_r  <= '0;
      blink_hide_r <= 1'b0;
      flash_mask_r <= {bus.point_p2, bus.point_p1};
      if (reach_s != 2'b00) begin
        winner_r <= reach_s;
      end
    end else if (bus.frame_tick && (state_r != PLAY)) begin
      // blink_hide_r tracks the parity of frames/BLINK_FRAMES without a divider
      if (flash_cnt_r != FC_W'(FLASH_FRAMES)) begin
        flash_cnt_r <= flash_cnt_r + 1'b1;
      end
      if (blink_cnt_r == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_r  <= '0;
        blink_hide_r <= ~blink_hide_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 1'b1;
      end
    end
  end

  // Digit rendering for the current pixel, tens digits blanked when zero
  always_comb begin
    x_s         = {1'b0, bus.h_count};
    y_s         = {1'b0, bus.v_count};
    tens1_seg_s = (score1_r[7:4] == 4'd0) ? 7'b0000000 : seg_map(score1_r[7:4]);
    unit1_seg_s = seg_map(score1_r[3:0]);
    tens2_seg_s = (score2_r[7:4] == 4'd0) ? 7'b0000000 : seg_map(score2_r[7:4]);
    unit2_seg_s = seg_map(score2_r[3:0]);
    pix_s = (visible_s[0] & (digit_hit(x_s, y_s, TENS_X, P1_YW, tens1_seg_s) |
                             digit_hit(x_s, y_s, UNIT_X, P1_YW, unit1_seg_s))) |
            (visible_s[1] & (digit_hit(x_s, y_s, TENS_X, P2_YW, tens2_seg_s) |
                             digit_hit(x_s, y_s, UNIT_X, P2_YW, unit2_seg_s)));
  end

  // Pixel output register
  always_ff @(posedge clk) begin
    if (reset) begin
      green_r <= 1'b0;
    end else begin
      green_r <= pix_s;
    end
  end

  assign bus.red       = 1'b0;
  assign bus.blue      = 1'b0;
  assign bus.green     = green_r;
  assign bus.score_p1  = score1_r;
  assign bus.score_p2  = score2_r;
  assign bus.game_over = game_over_s;
  assign bus.winner    = winner_r;

endmodule

// File: tb/tb_score_display_bcd.sv
// Randomised scoreboard bench for score_display_bcd: a frame/score reference model predicts
// every cycle's outputs, and a negedge monitor pops and compares them one cycle later.
module tb_score_display_bcd;
  localparam int SEG_LEN      = 40;
  localparam int SEG_THK      = 10;
  localparam int DIGIT_X      = 550;
  localparam int DIGIT_GAP    = 20;
  localparam int P1_Y         = 20;
  localparam int P2_Y         = 380;
  localparam int MAX_SCORE    = 10;
  localparam int FLASH_FRAMES = 60;
  localparam int BLINK_FRAMES = 8;

  typedef struct {
    int       due;
    bit       g;
    int       s1;
    int       s2;
    bit       go;
    int       w;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  // reference model: scores as integers, mode 0=play 1=flash 2=win, k = frames since last point
  int     m_s1, m_s2, m_mode, m_k;
  bit [1:0] m_mask, m_win;
  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};

  score_display_bcd_if bus ();

  score_display_bcd #(
    .SEG_LEN(SEG_LEN), .SEG_THK(SEG_THK), .DIGIT_X(DIGIT_X), .DIGIT_GAP(DIGIT_GAP),
    .P1_Y(P1_Y), .P2_Y(P2_Y), .MAX_SCORE(MAX_SCORE), .FLASH_FRAMES(FLASH_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit rect(int x, int y, int x0, int x1, int y0, int y1);
    return (x >= x0) && (x < x1) && (y >= y0) && (y < y1);
  endfunction

  function automatic bit digit_px(int d, int x, int y, int ox, int oy);
    logic [6:0] s;
    int L, T, V;
    L = SEG_LEN; T = SEG_THK; V = SEG_LEN - SEG_THK;
    s = seg_tab[d];
    return (s[6] && rect(x, y, ox, ox + L, oy, oy + T)) ||
           (s[5] && rect(x, y, ox + V, ox + L, oy, oy + V + T)) ||
           (s[4] && rect(x, y, ox + V, ox + L, oy + V, oy + 2*V + T)) ||
           (s[3] && rect(x, y, ox, ox + L, oy + 2*V, oy + 2*V + T)) ||
           (s[2] && rect(x, y, ox, ox + T, oy + V, oy + 2*V + T)) ||
           (s[1] && rect(x, y, ox, ox + T, oy, oy + V + T)) ||
           (s[0] && rect(x, y, ox, ox + L, oy + V, oy + V + T));
  endfunction

  function automatic bit player_px(int score, int x, int y, int oy);
    int tx;
    tx = DIGIT_X - SEG_LEN - DIGIT_GAP;
    return ((score / 10 != 0) && digit_px(score / 10, x, y, tx, oy)) ||
           digit_px(score % 10, x, y, DIGIT_X, oy);
  endfunction

  function automatic bit model_pixel(int x, int y);
    bit hid, v1, v2;
    hid = ((m_k / BLINK_FRAMES) % 2) == 1;
    v1 = !(hid && ((m_mode == 1 && m_mask[0]) || (m_mode == 2 && m_win[0])));
    v2 = !(hid && ((m_mode == 1 && m_mask[1]) || (m_mode == 2 && m_win[1])));
    return (v1 && player_px(m_s1, x, y, P1_Y)) || (v2 && player_px(m_s2, x, y, P2_Y));
  endfunction

  function automatic void model_update(bit rst, bit p1, bit p2, bit rs, bit ft);
    if (rst || rs) begin
      m_s1 = 0; m_s2 = 0; m_mode = 0; m_k = 0; m_mask = 2'b00; m_win = 2'b00;
    end else if (m_mode != 2 && (p1 || p2)) begin
      if (p1 && m_s1 < MAX_SCORE) m_s1++;
      if (p2 && m_s2 < MAX_SCORE) m_s2++;
      m_mask = {p2, p1};
      m_k = 0;
      if (m_s1 == MAX_SCORE || m_s2 == MAX_SCORE) begin
        m_mode = 2;
        m_win = {m_s2 == MAX_SCORE, m_s1 == MAX_SCORE};
      end else begin
        m_mode = 1;
      end
    end else if (m_mode == 1 && m_k == FLASH_FRAMES) begin
      m_mode = 0;
    end else if (ft && m_mode != 0) begin
      m_k++;
    end
  endfunction

  function automatic int bcd(int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic step(input bit rst, input bit p1, input bit p2, input bit rs, input bit ft,
                      input int x, input int y);
    exp_t e;
    reset = rst;
    bus.point_p1 = p1; bus.point_p2 = p2; bus.restart = rs; bus.frame_tick = ft;
    bus.h_count = 10'(x); bus.v_count = 10'(y);
    e.due = cyc + 1;
    e.g = rst ? 1'b0 : model_pixel(x, y);
    model_update(rst, p1, p2, rs, ft);
    e.s1 = bcd(m_s1); e.s2 = bcd(m_s2);
    e.go = (m_mode == 2); e.w = int'(m_win);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pick(output int x, output int y);
    case ($urandom_range(0, 4))
      0: begin x = $urandom_range(480, 600); y = $urandom_range(10, 115); end
      1: begin x = $urandom_range(480, 600); y = $urandom_range(370, 475); end
      2: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
      3: begin x = $urandom_range(515, 595); y = $urandom_range(15, 95); end
      default: begin x = $urandom_range(1000, 1023); y = $urandom_range(1000, 1023); end
    endcase
  endtask

  task automatic idle(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      pick(x, y);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, x, y);
    end
  endtask

  task automatic ev(input bit rst, input bit p1, input bit p2, input bit rs, input bit ft);
    int x, y;
    pick(x, y);
    step(rst, p1, p2, rs, ft, x, y);
  endtask

  task automatic px(input int x, input int y);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, x, y);
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      px(585, 30); px(585, 390); px(525, 30); px(525, 390);
      idle(3);
    end
  endtask

  // scoreboard monitor: pops the prediction due this cycle and compares every output
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0 && q[0].due < cyc) begin
      e = q.pop_front();
      check("stale_prediction", cyc, e.due);
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("green", int'(bus.green), int'(e.g));
      check("red", int'(bus.red), 0);
      check("blue", int'(bus.blue), 0);
      check("score_p1", int'(bus.score_p1), e.s1);
      check("score_p2", int'(bus.score_p2), e.s2);
      check("game_over", int'(bus.game_over), int'(e.go));
      check("winner", int'(bus.winner), e.w);
    end
  end

  initial begin
    reset = 1'b1;
    bus.point_p1 = 1'b0; bus.point_p2 = 1'b0; bus.restart = 1'b0; bus.frame_tick = 1'b0;
    bus.h_count = 10'd0; bus.v_count = 10'd0;
    m_s1 = 0; m_s2 = 0; m_mode = 0; m_k = 0; m_mask = 2'b00; m_win = 2'b00;
    @(posedge clk);
    #1;
    ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // score 00: units '0' only, tens blank
    px(550, 20); px(560, 30); px(575, 80); px(550, 380); px(495, 25); px(1023, 1023);
    idle(150);
    // player 1 to 09, then 10 (tens '1' at x=490) which is also the win
    for (int i = 0; i < 9; i++) begin
      ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
    end
    px(525, 30); idle(60);
    ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    px(525, 30); px(525, 85); px(490, 20); idle(60);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frames(20);
    // simultaneous point: both blink, hidden on frames 8..15
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(66);
    // restart with same-cycle points ignores the points
    ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    // re-point during flash at frame 30 restarts the flash
    ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frames(30);
    ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frames(64);
    // player 2 wins; later points ignored; winner keeps blinking
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
    end
    ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(20);
    // tie at 9-9 then a simultaneous point
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ev(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frames(18);
    // reset in the middle of a flash together with a point pulse
    ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frames(3);
    ev(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    // random soak
    for (int i = 0; i < 3000; i++) begin
      ev($urandom_range(0, 299) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0,
         $urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0);
    end
    idle(3);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
